// File: rtl/obj_motion_ctrl.sv
// Frame-rate object motion and shape-select control for the VGA shape renderer.
// Moves the object centre once per frame with wall bounce. Debounced keys select the shape and pause motion.

module obj_motion_ctrl_deb #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    vld_q, vld_d;
  logic          arm_q, arm_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // A key only arms once it has really been sampled released after reset,
  // so a key held through reset release cannot produce a press.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    arm_d   = arm_q | (vld_q[1] & sync2_q);
    acc_d   = acc_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_MAX) begin
        acc_d   = sync2_q;
        press_d = ~sync2_q & arm_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld_q   <= 2'b00;
      arm_q   <= 1'b0;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      arm_q   <= arm_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module obj_motion_ctrl #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int HALF       = 25,
  parameter int STEP       = 2,
  parameter int X_INIT     = 305,
  parameter int Y_INIT     = 215,
  parameter int DEB_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_vs,
  input  logic        key_next,
  input  logic        key_pause,
  output logic [12:0] objX,
  output logic [12:0] objY,
  output logic [1:0]  img,
  output logic        moving,
  output logic        frame_tick
);

  localparam logic [13:0] LO   = 14'(HALF);
  localparam logic [13:0] X_HI = 14'(H_ACT - 1 - HALF);
  localparam logic [13:0] Y_HI = 14'(V_ACT - 1 - HALF);

  typedef enum logic {RUN, PAUSE} state_t;

  state_t      state_q, state_d;
  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  logic        tick_q, tick_d;
  logic [12:0] x_q, x_d, y_q, y_d;
  logic        xdir_q, xdir_d, ydir_q, ydir_d;
  logic [1:0]  img_q, img_d;
  logic        next_press, pause_press;

  obj_motion_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_next),
    .press (next_press)
  );

  obj_motion_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_pause),
    .press (pause_press)
  );

  // Returns {direction, position}; direction 1 means increasing coordinate.
  function automatic logic [13:0] axis_step(input logic [12:0] pos, input logic up,
                                            input logic [13:0] hi);
    logic [13:0] p, step, sum, dif;
    p    = {1'b0, pos};
    step = 14'(STEP);
    sum  = p + step;
    dif  = p - step;
    axis_step = {up, pos};
    if (up) begin
      if (sum > hi) axis_step = {1'b0, hi[12:0]};
      else          axis_step = {1'b1, sum[12:0]};
    end else begin
      if (p < LO + step) axis_step = {1'b1, LO[12:0]};
      else               axis_step = {1'b0, dif[12:0]};
    end
  endfunction

  // Motion uses the state before any pause press arriving in the same cycle.
  always_comb begin
    tick_d  = vs_s2_q & ~vs_s3_q;
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xdir_d  = xdir_q;
    ydir_d  = ydir_q;
    img_d   = img_q;
    if (tick_q && state_q == RUN) begin
      {xdir_d, x_d} = axis_step(x_q, xdir_q, X_HI);
      {ydir_d, y_d} = axis_step(y_q, ydir_q, Y_HI);
    end
    if (pause_press) state_d = (state_q == RUN) ? PAUSE : RUN;
    if (next_press)  img_d = img_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_s3_q <= 1'b1;
      tick_q  <= 1'b0;
      state_q <= RUN;
      x_q     <= 13'(X_INIT);
      y_q     <= 13'(Y_INIT);
      xdir_q  <= 1'b1;
      ydir_q  <= 1'b1;
      img_q   <= 2'd0;
    end else begin
      vs_s1_q <= vga_vs;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
      tick_q  <= tick_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
      img_q   <= img_d;
    end
  end

  assign objX       = x_q;
  assign objY       = y_q;
  assign img        = img_q;
  assign moving     = (state_q == RUN);
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_obj_motion_ctrl.sv
// Self-checking bench for obj_motion_ctrl: three parameterisations driven in parallel
// against a transaction-level model of position, direction, shape and run state.

module tb_obj_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vga_vs = 1'b0;
  logic key_next = 1'b1;
  logic key_pause = 1'b1;

  logic [12:0] ax, ay, bx, by, cx, cy;
  logic [1:0]  aimg, bimg, cimg;
  logic        amov, bmov, cmov, atick, btick, ctick;

  always #5 clk = ~clk;

  obj_motion_ctrl #(.DEB_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .vga_vs(vga_vs), .key_next(key_next), .key_pause(key_pause),
    .objX(ax), .objY(ay), .img(aimg), .moving(amov), .frame_tick(atick)
  );

  obj_motion_ctrl #(.X_INIT(613), .Y_INIT(453), .DEB_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .vga_vs(vga_vs), .key_next(key_next), .key_pause(key_pause),
    .objX(bx), .objY(by), .img(bimg), .moving(bmov), .frame_tick(btick)
  );

  obj_motion_ctrl #(.H_ACT(64), .V_ACT(60), .HALF(5), .STEP(3), .X_INIT(10), .Y_INIT(40),
                    .DEB_CYCLES(4)) u_c (
    .clk(clk), .rst(rst), .vga_vs(vga_vs), .key_next(key_next), .key_pause(key_pause),
    .objX(cx), .objY(cy), .img(cimg), .moving(cmov), .frame_tick(ctick)
  );

  localparam int DEB = 4;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state per instance: position, direction (+1/-1), arena limits.
  int mx[3], my[3], mdx[3], mdy[3];
  int lo[3], hx[3], hy[3], st[3], xi[3], yi[3];
  int mimg;
  bit mmov;

  typedef struct {
    logic vs;
    logic exp_tick;
  } vec_t;
  vec_t vecs[14];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    lo[0] = 25; hx[0] = 614; hy[0] = 454; st[0] = 2; xi[0] = 305; yi[0] = 215;
    lo[1] = 25; hx[1] = 614; hy[1] = 454; st[1] = 2; xi[1] = 613; yi[1] = 453;
    lo[2] = 5;  hx[2] = 58;  hy[2] = 54;  st[2] = 3; xi[2] = 10;  yi[2] = 40;
    for (int i = 0; i < 3; i++) begin
      mx[i] = xi[i]; my[i] = yi[i]; mdx[i] = 1; mdy[i] = 1;
    end
    mimg = 0;
    mmov = 1'b1;
  endtask

  // Wall bounce: overshooting a wall parks the object on it and reverses.
  function automatic void move(inout int p, inout int d, input int l, input int h, input int s);
    if (d > 0) begin
      if (p + s > h) begin p = h; d = -1; end
      else p = p + s;
    end else begin
      if (p - s < l) begin p = l; d = 1; end
      else p = p - s;
    end
  endfunction

  task automatic model_tick();
    if (mmov) begin
      for (int i = 0; i < 3; i++) begin
        move(mx[i], mdx[i], lo[i], hx[i], st[i]);
        move(my[i], mdy[i], lo[i], hy[i], st[i]);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_output($sformatf("%s a.x", tag), int'(ax), mx[0]);
    check_output($sformatf("%s a.y", tag), int'(ay), my[0]);
    check_output($sformatf("%s b.x", tag), int'(bx), mx[1]);
    check_output($sformatf("%s b.y", tag), int'(by), my[1]);
    check_output($sformatf("%s c.x", tag), int'(cx), mx[2]);
    check_output($sformatf("%s c.y", tag), int'(cy), my[2]);
    check_output($sformatf("%s a.img", tag), int'(aimg), mimg);
    check_output($sformatf("%s c.img", tag), int'(cimg), mimg);
    check_output($sformatf("%s a.moving", tag), int'(amov), int'(mmov));
    check_output($sformatf("%s c.moving", tag), int'(cmov), int'(mmov));
    check_output($sformatf("%s b.tick", tag), int'(btick), 0);
  endtask

  task automatic vs_pulse();
    int seen = 0;
    vga_vs = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) vga_vs = 1'b0;
      cyc(1);
      if (atick) seen++;
    end
    check_output("tick_per_pulse", seen, 1);
    model_tick();
  endtask

  task automatic apply_stimulus(input bit is_next, input int low_cycles);
    if (is_next) key_next = 1'b0;
    else         key_pause = 1'b0;
    cyc(low_cycles);
    key_next = 1'b1;
    key_pause = 1'b1;
    cyc(12);
    if (low_cycles >= DEB) begin
      if (is_next) mimg = (mimg + 1) % 4;
      else         mmov = !mmov;
    end
  endtask

  task automatic press_both();
    key_next = 1'b0;
    key_pause = 1'b0;
    cyc(8);
    key_next = 1'b1;
    key_pause = 1'b1;
    cyc(12);
    mimg = (mimg + 1) % 4;
    mmov = !mmov;
  endtask

  // Key press event and frame tick land in the same cycle.
  task automatic aligned(input bit is_next);
    if (is_next) key_next = 1'b0;
    else         key_pause = 1'b0;
    cyc(3);
    vga_vs = 1'b1;
    cyc(2);
    vga_vs = 1'b0;
    cyc(3);
    key_next = 1'b1;
    key_pause = 1'b1;
    cyc(12);
    model_tick();
    if (is_next) mimg = (mimg + 1) % 4;
    else         mmov = !mmov;
  endtask

  initial begin
    int exp_seq[4];
    int lat;
    int r;

    model_reset();
    vecs[0]  = '{1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0};

    #2 rst = 1'b0;
    #1;
    check_output("rst0 a.x", int'(ax), 305);
    check_output("rst0 a.y", int'(ay), 215);
    check_output("rst0 a.img", int'(aimg), 0);
    check_output("rst0 a.moving", int'(amov), 1);
    check_output("rst0 a.tick", int'(atick), 0);
    cyc(3);
    rst = 1'b1;
    cyc(4);

    for (int i = 0; i < 14; i++) begin
      vga_vs = vecs[i].vs;
      cyc(1);
      check_output($sformatf("tick_vec[%0d]", i), int'(atick), int'(vecs[i].exp_tick));
      if (vecs[i].exp_tick) model_tick();
    end
    cyc(2);
    check_all("after_table");

    rst = 1'b0;
    #1;
    check_output("rst_mid a.x", int'(ax), 305);
    check_output("rst_mid a.y", int'(ay), 215);
    check_output("rst_mid a.tick", int'(atick), 0);
    model_reset();
    cyc(2);
    rst = 1'b1;
    cyc(4);
    for (int i = 0; i < 10; i++) begin
      vs_pulse();
      if (i == 0) begin
        check_output("bounce1 b.x", int'(bx), 614);
        check_output("bounce1 b.y", int'(by), 454);
      end
      if (i == 1) begin
        check_output("bounce2 b.x", int'(bx), 612);
        check_output("bounce2 b.y", int'(by), 452);
      end
    end
    check_output("ten_ticks a.x", int'(ax), 325);
    check_output("ten_ticks a.y", int'(ay), 235);
    check_all("ten_ticks");

    apply_stimulus(1'b0, 10);
    check_output("pause a.moving", int'(amov), 0);
    repeat (5) vs_pulse();
    check_all("paused");
    apply_stimulus(1'b0, 10);
    check_output("resume a.moving", int'(amov), 1);
    repeat (3) vs_pulse();
    check_all("resumed");

    apply_stimulus(1'b1, 3);
    check_output("glitch a.img", int'(aimg), 0);
    exp_seq = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 6);
      check_output($sformatf("shape[%0d]", i), int'(aimg), exp_seq[i]);
    end
    apply_stimulus(1'b1, 1000);
    check_output("long_hold a.img", int'(aimg), 1);
    check_all("shapes");

    key_next = 1'b0;
    lat = 0;
    while (aimg == 2'(mimg) && lat < 20) begin
      cyc(1);
      lat++;
    end
    check_output("press_latency", lat, 3 + DEB);
    key_next = 1'b1;
    cyc(12);
    mimg = (mimg + 1) % 4;
    check_all("latency");

    aligned(1'b0);
    check_output("aligned_pause a.moving", int'(amov), 0);
    check_all("aligned_pause");
    vs_pulse();
    check_all("aligned_pause_held");
    apply_stimulus(1'b0, 6);
    aligned(1'b1);
    check_all("aligned_next");
    press_both();
    check_all("both_keys");
    press_both();
    vs_pulse();
    check_all("both_keys2");

    key_next = 1'b0;
    cyc(3);
    rst = 1'b0;
    #1;
    check_output("rst_deb a.img", int'(aimg), 0);
    check_output("rst_deb a.moving", int'(amov), 1);
    model_reset();
    cyc(2);
    rst = 1'b1;
    cyc(20);
    check_output("held_through_rst a.img", int'(aimg), 0);
    key_next = 1'b1;
    cyc(12);
    apply_stimulus(1'b1, 8);
    check_output("after_held a.img", int'(aimg), 1);
    check_all("held_through_rst");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      vs_pulse();
      else if (r < 8) apply_stimulus(1'b1, $urandom_range(2, 8));
      else if (r < 9) apply_stimulus(1'b0, $urandom_range(2, 8));
      else            press_both();
      check_all($sformatf("rand[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
